phv_queue_dispatch: RTL and testbench

- Output dispatcher placed after the action engine of the final pipeline stage.
- Takes one PHV per handshake and reads its destination-queue bitmap.
- Copies the PHV into a per-queue output FIFO for every set bit, so one PHV can go to several queues (multicast).
- Generalises the single-output stage tail to C_NUM_QUEUES channels, with correct backpressure and drop handling for an all-zero bitmap.

---
 rtl/phv_dispatch_pkg.sv | 20 ++
 rtl/phv_dispatch_fifo.sv | 72 +++++++
 rtl/phv_queue_dispatch.sv | 78 +++++++
 tb/tb_phv_queue_dispatch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/phv_dispatch_pkg.sv
// Shared defaults and helpers for the PHV queue dispatcher.
// Counter widths up to 64 bits are supported by sat_inc.
package phv_dispatch_pkg;

  localparam int PHV_LEN_DEF   = 1024;
  localparam int QMAP_OFF_DEF  = 141;
  localparam int CNT_WIDTH_DEF = 32;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val == max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/phv_dispatch_fifo.sv
// First-word-fall-through channel FIFO; the head entry is presented from a register
// so o_data holds its last value while the FIFO is empty.
module phv_dispatch_fifo
  import phv_dispatch_pkg::*;
#(
  parameter int WIDTH = PHV_LEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_rd_next;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] w_head_next;

  assign o_valid      = (r_count != '0);
  assign o_full       = (r_count == CW'(DEPTH));
  assign o_data       = r_data;
  assign w_pop        = o_valid & i_ready;
  assign w_push       = i_push & ~o_full;
  assign w_rd_next    = r_rd_ptr + PW'(w_pop);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // The incoming word becomes the head only when nothing else survives this edge.
  always_comb begin
    // NOTE: default assigned first so every path drives w_head_next; no latch is inferred.
    w_head_next = r_data;
    if (w_count_next != '0) begin
      if (w_push && ((r_count - CW'(w_pop)) == '0)) w_head_next = i_data;
      else                                           w_head_next = r_mem[w_rd_next];
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together.
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_count  <= w_count_next;
      r_data   <= w_head_next;
    end
  end

endmodule

// File: rtl/phv_queue_dispatch.sv
// Multicast PHV dispatcher: copies each accepted PHV into every channel FIFO named
// by its queue bitmap. Statistics counters exist only when DISPATCH_STATS_EN is defined.
module phv_queue_dispatch
  import phv_dispatch_pkg::*;
#(
  parameter int PHV_LEN      = PHV_LEN_DEF,
  parameter int C_NUM_QUEUES = 4,
  parameter int QMAP_OFF     = QMAP_OFF_DEF,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                            axis_clk,
  input  logic                            areset,
  input  logic [PHV_LEN-1:0]              phv_in,
  input  logic                            phv_valid_in,
  output logic                            phv_ready_out,
  output logic [C_NUM_QUEUES*PHV_LEN-1:0] phv_out,
  output logic [C_NUM_QUEUES-1:0]         phv_valid_out,
  input  logic [C_NUM_QUEUES-1:0]         phv_ready_in
`ifdef DISPATCH_STATS_EN
  ,
  output logic [C_NUM_QUEUES*CNT_WIDTH-1:0] stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              stat_drop_cnt
`endif
);

  logic [C_NUM_QUEUES-1:0] w_qmap;
  logic [C_NUM_QUEUES-1:0] w_full;
  logic [C_NUM_QUEUES-1:0] w_push;
  logic                    w_accept;

  // A single full channel stalls every channel so a multicast never splits.
  assign phv_ready_out = ~|w_full;
  assign w_accept      = phv_valid_in & phv_ready_out;
  assign w_qmap        = phv_in[QMAP_OFF +: C_NUM_QUEUES];
  assign w_push        = {C_NUM_QUEUES{w_accept}} & w_qmap;

  for (genvar q = 0; q < C_NUM_QUEUES; q++) begin : g_chan
    phv_dispatch_fifo #(
      .WIDTH (PHV_LEN),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (axis_clk),
      .rst     (areset),
      .i_push  (w_push[q]),
      .i_data  (phv_in),
      .o_full  (w_full[q]),
      .o_valid (phv_valid_out[q]),
      .i_ready (phv_ready_in[q]),
      .o_data  (phv_out[q*PHV_LEN +: PHV_LEN])
    );
  end

`ifdef DISPATCH_STATS_EN
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic                 w_drop;

  assign w_drop        = w_accept & (w_qmap == '0);
  assign stat_drop_cnt = r_drop_cnt;

  always_ff @(posedge axis_clk) begin
    if (areset)      r_drop_cnt <= '0;
    else if (w_drop) r_drop_cnt <= CNT_WIDTH'(sat_inc(64'(r_drop_cnt), CNT_WIDTH));
  end

  for (genvar q = 0; q < C_NUM_QUEUES; q++) begin : g_stat
    logic [CNT_WIDTH-1:0] r_pkt_cnt;

    assign stat_pkt_cnt[q*CNT_WIDTH +: CNT_WIDTH] = r_pkt_cnt;

    always_ff @(posedge axis_clk) begin
      if (areset)         r_pkt_cnt <= '0;
      else if (w_push[q]) r_pkt_cnt <= CNT_WIDTH'(sat_inc(64'(r_pkt_cnt), CNT_WIDTH));
    end
  end
`endif

endmodule

// File: tb/tb_phv_queue_dispatch.sv
// Self-checking bench for phv_queue_dispatch: directed table, multi-cycle corner
// sequences and random traffic against a queue-based reference model.
module tb_phv_queue_dispatch;

  localparam int PHV   = 1024;
  localparam int NQ    = 4;
  localparam int QOFF  = 141;
  localparam int DEPTH = 4;
  localparam int CW    = 32;

  typedef logic [PHV-1:0] phv_t;

  typedef struct {
    logic          v;
    logic [NQ-1:0] qm;
    logic [NQ-1:0] rin;
    logic          exp_rdy;
    logic [NQ-1:0] exp_vld;
  } vec_t;

  logic                 axis_clk = 1'b0;
  logic                 areset;
  phv_t                 phv_in;
  logic                 phv_valid_in;
  logic                 phv_ready_out;
  logic [NQ*PHV-1:0]    phv_out;
  logic [NQ-1:0]        phv_valid_out;
  logic [NQ-1:0]        phv_ready_in;
`ifdef DISPATCH_STATS_EN
  logic [NQ*CW-1:0]     stat_pkt_cnt;
  logic [CW-1:0]        stat_drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  phv_t mq [NQ][$];
  phv_t mlast [NQ];
  int   mpkt [NQ];
  int   mdrop;

  always #5 axis_clk = ~axis_clk;

  phv_queue_dispatch #(
    .PHV_LEN      (PHV),
    .C_NUM_QUEUES (NQ),
    .QMAP_OFF     (QOFF),
    .FIFO_DEPTH   (DEPTH),
    .CNT_WIDTH    (CW)
  ) dut (
    .axis_clk      (axis_clk),
    .areset        (areset),
    .phv_in        (phv_in),
    .phv_valid_in  (phv_valid_in),
    .phv_ready_out (phv_ready_out),
    .phv_out       (phv_out),
    .phv_valid_out (phv_valid_out),
    .phv_ready_in  (phv_ready_in)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_drop_cnt (stat_drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_phv(input string name, input phv_t act, input phv_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got low128 %h expected low128 %h (t=%0t)", name, act[127:0], exp[127:0], $time);
    end
  endtask

  function automatic phv_t make_phv(input logic [NQ-1:0] qm);
    phv_t p;
    for (int w = 0; w < PHV/32; w++) p[w*32 +: 32] = $urandom;
    p[QOFF +: NQ] = qm;
    return p;
  endfunction

  function automatic void model_clear();
    for (int q = 0; q < NQ; q++) begin
      mq[q].delete();
      mlast[q] = '0;
      mpkt[q]  = 0;
    end
    mdrop = 0;
  endfunction

  // Compare every output with the model, then advance both across one clock edge.
  task automatic step(input logic v, input logic [NQ-1:0] qm, input logic [NQ-1:0] rin,
                      output logic acc);
    phv_t p;
    logic mready;
    p = make_phv(qm);
    phv_valid_in = v;
    phv_in       = p;
    phv_ready_in = rin;
    #1;
    mready = 1'b1;
    for (int q = 0; q < NQ; q++) if (mq[q].size() >= DEPTH) mready = 1'b0;
    check("ready_out", 64'(phv_ready_out), 64'(mready));
    for (int q = 0; q < NQ; q++) begin
      check($sformatf("valid_ch%0d", q), 64'(phv_valid_out[q]), 64'(mq[q].size() > 0));
      check_phv($sformatf("data_ch%0d", q), phv_out[q*PHV +: PHV],
                (mq[q].size() > 0) ? mq[q][0] : mlast[q]);
`ifdef DISPATCH_STATS_EN
      check($sformatf("pkt_cnt_ch%0d", q), 64'(stat_pkt_cnt[q*CW +: CW]), 64'(mpkt[q]));
`endif
    end
`ifdef DISPATCH_STATS_EN
    check("drop_cnt", 64'(stat_drop_cnt), 64'(mdrop));
`endif
    acc = v & mready;
    @(posedge axis_clk);
    for (int q = 0; q < NQ; q++) if (mq[q].size() > 0 && rin[q]) void'(mq[q].pop_front());
    if (acc) begin
      if (qm == '0) mdrop++;
      else for (int q = 0; q < NQ; q++) if (qm[q]) begin
        mq[q].push_back(p);
        mpkt[q]++;
      end
    end
    for (int q = 0; q < NQ; q++) if (mq[q].size() > 0) mlast[q] = mq[q][0];
    @(negedge axis_clk);
  endtask

  task automatic pulse_reset();
    areset       = 1'b1;
    phv_valid_in = 1'b0;
    @(posedge axis_clk);
    model_clear();
    @(negedge axis_clk);
    areset = 1'b0;
  endtask

  initial begin
    vec_t tbl [9];
    logic acc;
    int   sent;

    tbl[0] = '{1'b1, 4'b0001, 4'b1111, 1'b1, 4'b0000};
    tbl[1] = '{1'b1, 4'b1011, 4'b1111, 1'b1, 4'b0001};
    tbl[2] = '{1'b1, 4'b0000, 4'b1111, 1'b1, 4'b1011};
    tbl[3] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000};
    tbl[4] = '{1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0000};
    tbl[5] = '{1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0100};
    tbl[6] = '{1'b0, 4'b0000, 4'b0100, 1'b1, 4'b0100};
    tbl[7] = '{1'b0, 4'b0000, 4'b0100, 1'b1, 4'b0100};
    tbl[8] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000};

    areset       = 1'b1;
    phv_valid_in = 1'b0;
    phv_ready_in = '0;
    phv_in       = '0;
    model_clear();
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    areset = 1'b0;
    #1;
    check("rst_ready", 64'(phv_ready_out), 64'd1);
    check("rst_valid", 64'(phv_valid_out), 64'd0);
    for (int q = 0; q < NQ; q++) check_phv($sformatf("rst_data_ch%0d", q), phv_out[q*PHV +: PHV], '0);

    // Unicast, multicast, zero bitmap and a short two-deep backlog.
    for (int i = 0; i < 9; i++) begin
      #1;
      check($sformatf("tbl%0d_ready", i), 64'(phv_ready_out), 64'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d_valid", i), 64'(phv_valid_out), 64'(tbl[i].exp_vld));
      step(tbl[i].v, tbl[i].qm, tbl[i].rin, acc);
    end

    // Backpressure on channel 2: four accepts fill it, the fifth waits for a pop.
    sent = 0;
    for (int c = 0; c < 10 && sent < 4; c++) begin
      step(1'b1, 4'b0100, 4'b1011, acc);
      if (acc) sent++;
    end
    check("bp_four_accepted", 64'(sent), 64'd4);
    check("bp_ready_low", 64'(phv_ready_out), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'b0100, 4'b1011, acc);
      check("bp_stalled", 64'(acc), 64'd0);
    end
    step(1'b1, 4'b0100, 4'b1111, acc);
    check("bp_no_accept_on_pop", 64'(acc), 64'd0);
    check("bp_ready_back", 64'(phv_ready_out), 64'd1);
    step(1'b1, 4'b0100, 4'b1011, acc);
    check("bp_fifth_accepted", 64'(acc), 64'd1);
    for (int c = 0; c < 6; c++) step(1'b0, 4'b0000, 4'b1111, acc);
    check("bp_drained", 64'(phv_valid_out), 64'd0);

    // Channel 1 held at two entries with a push and a pop every cycle.
    step(1'b1, 4'b0010, 4'b1101, acc);
    step(1'b1, 4'b0010, 4'b1101, acc);
    for (int c = 0; c < 10; c++) step(1'b1, 4'b0010, 4'b1111, acc);
    step(1'b0, 4'b0000, 4'b1111, acc);
    #1 check("pp_one_left", 64'(phv_valid_out[1]), 64'd1);
    step(1'b0, 4'b0000, 4'b1111, acc);
    #1 check("pp_empty", 64'(phv_valid_out[1]), 64'd0);

    // Reset with three entries buffered in channel 0.
    for (int c = 0; c < 3; c++) step(1'b1, 4'b0001, 4'b0000, acc);
    #1 check("mid_rst_buffered", 64'(phv_valid_out[0]), 64'd1);
    pulse_reset();
    #1;
    check("mid_rst_valid", 64'(phv_valid_out), 64'd0);
    check("mid_rst_ready", 64'(phv_ready_out), 64'd1);
    check_phv("mid_rst_data_ch0", phv_out[PHV-1:0], '0);
`ifdef DISPATCH_STATS_EN
    check("mid_rst_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
    check("mid_rst_drop_cnt", 64'(stat_drop_cnt), 64'd0);
`endif
    step(1'b0, 4'b0000, 4'b1111, acc);

    // Random traffic including zero bitmaps and bursty downstream readiness.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, NQ'($urandom), NQ'($urandom | $urandom), acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
